// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel down-counter timer.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } t_state;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter with terminal-count expiry, reload register and trigger flop.
//   state | meaning
//   IDLE  | never loaded, or stopped by a zero load; count holds
//   COUNT | counting down while enable is high
//   DONE  | one-shot expired; waits for the next load
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_mode,
  output logic [WIDTH-1:0] count,
  output logic             trigger,
  output logic             done,
  output logic             busy
);

  t_state           state, state_n;
  logic [WIDTH-1:0] count_n, reload, reload_n;
  logic             mode, mode_n, trigger_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      mode    <= MODE_ONESHOT;
      trigger <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      reload  <= reload_n;
      mode    <= mode_n;
      trigger <= trigger_n;
    end
  end

  // A load wins over decrement/expiry in the same cycle, so no trigger can escape it.
  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload;
    mode_n    = mode;
    trigger_n = 1'b0;
    if (load) begin
      count_n  = load_value;
      reload_n = load_value;
      mode_n   = load_mode;
      state_n  = (load_value != '0) ? COUNT : IDLE;
    end else if (state == COUNT && enable) begin
      if (count == WIDTH'(1)) begin
        trigger_n = 1'b1;
        if (mode == MODE_PERIODIC) begin
          count_n = reload;
        end else begin
          count_n = '0;
          state_n = DONE;
        end
      end else if (count != '0) begin
        count_n = count - WIDTH'(1);
      end
    end
  end

  assign done = (state == DONE);
  assign busy = (state == COUNT);

endmodule

// File: rtl/multi_timer.sv
// N independent timer channels with a shared load port, count readback mux and combined irq.
module multi_timer #(
  parameter  int N_CHAN = 4,
  parameter  int WIDTH  = 16,
  localparam int CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CHAN-1:0] enable,
  input  logic              load_valid,
  input  logic [CHAN_W-1:0] load_chan,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              load_mode,
  input  logic [CHAN_W-1:0] rd_chan,
  output logic [WIDTH-1:0]  rd_count,
  output logic [N_CHAN-1:0] trigger,
  output logic [N_CHAN-1:0] done,
  output logic [N_CHAN-1:0] busy,
  output logic              irq
);

  logic [WIDTH-1:0]  chan_count [N_CHAN];
  logic [N_CHAN-1:0] load_sel;

  // Out-of-range load_chan matches no channel and is dropped.
  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    assign load_sel[i] = load_valid && (load_chan == CHAN_W'(i));

    timer_channel #(.WIDTH(WIDTH)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable[i]),
      .load       (load_sel[i]),
      .load_value (load_value),
      .load_mode  (load_mode),
      .count      (chan_count[i]),
      .trigger    (trigger[i]),
      .done       (done[i]),
      .busy       (busy[i])
    );
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (rd_chan == CHAN_W'(i)) rd_count = chan_count[i];
    end
  end

  assign irq = |trigger;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboarded bench for multi_timer: directed scenarios then random traffic against an elapsed-cycle model.
module tb_multi_timer;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  enable;
  logic          load_valid;
  logic [CW-1:0] load_chan;
  logic [W-1:0]  load_value;
  logic          load_mode;
  logic [CW-1:0] rd_chan;
  logic [W-1:0]  rd_count;
  logic [N-1:0]  trigger, done, busy;
  logic          irq;

  always #5 clk = ~clk;

  multi_timer #(.N_CHAN(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_chan(load_chan), .load_value(load_value), .load_mode(load_mode),
    .rd_chan(rd_chan), .rd_count(rd_count), .trigger(trigger), .done(done),
    .busy(busy), .irq(irq)
  );

  typedef struct {
    logic [W-1:0] rd;
    logic [N-1:0] trig;
    logic [N-1:0] dn;
    logic [N-1:0] bsy;
    logic         irq;
  } exp_t;

  exp_t sb[$];
  event async_chk;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: each channel remembers its load value, mode and how many enabled cycles it has counted.
  int unsigned mv [N];
  int unsigned mn [N];
  bit          mp [N];

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mn[i] = 0; mp[i] = 1'b0;
    end
  endfunction

  function automatic bit m_expired(int i);
    return (mv[i] != 0) && !mp[i] && (mn[i] >= mv[i]);
  endfunction

  function automatic int unsigned m_count(int i);
    if (mv[i] == 0 || m_expired(i)) return 0;
    return mv[i] - (mn[i] % mv[i]);
  endfunction

  function automatic exp_t expect_now(logic [N-1:0] tr, int rc);
    exp_t e;
    e.trig = tr;
    e.irq  = |tr;
    for (int i = 0; i < N; i++) begin
      e.dn[i]  = m_expired(i);
      e.bsy[i] = (mv[i] != 0) && !m_expired(i);
    end
    e.rd = (rc < N) ? W'(m_count(rc)) : '0;
    return e;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endfunction

  // Called at a negedge: drive inputs, predict the state after the coming posedge, then wait a cycle.
  task automatic cycle(input logic [N-1:0] en, input bit lv, input int lc,
                       input int lval, input bit lm, input int rc);
    logic [N-1:0] tr;
    tr         = '0;
    enable     = en;
    load_valid = lv;
    load_chan  = CW'(lc);
    load_value = W'(lval);
    load_mode  = lm;
    rd_chan    = CW'(rc);
    if (reset) begin
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (lv && lc == i) begin
          mv[i] = lval; mp[i] = lm; mn[i] = 0;
        end else if (mv[i] != 0 && en[i] && (mp[i] || mn[i] < mv[i])) begin
          mn[i]++;
          if (mn[i] % mv[i] == 0) tr[i] = 1'b1;
        end
      end
    end
    sb.push_back(expect_now(tr, rc));
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic [N-1:0] en, input int rc);
    for (int k = 0; k < n; k++) cycle(en, 1'b0, 0, 0, 1'b0, rc);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic async_reset(input int hold);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_clear();
    sb.push_back(expect_now('0, int'(rd_chan)));
    -> async_chk;
    @(negedge clk);
    idle_cycles(hold, '1, int'(rd_chan));
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or async_chk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rd_count", 32'(rd_count), 32'(e.rd));
        check("trigger",  32'(trigger),  32'(e.trig));
        check("done",     32'(done),     32'(e.dn));
        check("busy",     32'(busy),     32'(e.bsy));
        check("irq",      32'(irq),      32'(e.irq));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; enable = '0; load_valid = 1'b0; load_chan = '0;
    load_value = '0; load_mode = 1'b0; rd_chan = '0;
    model_clear();
    @(negedge clk);
    idle_cycles(2, '1, 0);
    reset = 1'b0;

    // one-shot 5 on ch0
    cycle('1, 1'b1, 0, 5, 1'b0, 0);
    idle_cycles(8, '1, 0);
    // periodic 3 on ch1, four periods
    cycle('1, 1'b1, 1, 3, 1'b1, 1);
    idle_cycles(12, '1, 1);
    // ch2 paused at count 2 for three cycles
    cycle('1, 1'b1, 2, 4, 1'b0, 2);
    idle_cycles(2, '1, 2);
    idle_cycles(3, 6'b111011, 2);
    idle_cycles(4, '1, 2);
    // ch3 reloaded at count 1, then zero load
    cycle('1, 1'b1, 3, 3, 1'b0, 3);
    idle_cycles(2, '1, 3);
    cycle('1, 1'b1, 3, 7, 1'b0, 3);
    idle_cycles(1, '1, 3);
    cycle('1, 1'b1, 3, 0, 1'b0, 3);
    idle_cycles(2, '1, 3);
    // ch0 and ch1 expire together
    cycle('1, 1'b1, 0, 5, 1'b0, 0);
    cycle('1, 1'b1, 1, 4, 1'b0, 1);
    idle_cycles(6, '1, 0);
    // V=1 periodic, out-of-range load/readback, load while disabled
    cycle('1, 1'b1, 4, 1, 1'b1, 4);
    idle_cycles(4, '1, 4);
    cycle('1, 1'b1, 7, 9, 1'b0, 6);
    cycle(6'b011111, 1'b1, 5, 2, 1'b0, 5);
    idle_cycles(3, 6'b011111, 5);
    // maximum count
    cycle('1, 1'b1, 5, 255, 1'b0, 5);
    idle_cycles(257, '1, 5);
    // reset mid-count on all channels
    for (int i = 0; i < N; i++) cycle('1, 1'b1, i, 6 + i, i % 2, i);
    idle_cycles(2, '1, 2);
    async_reset(2);
    idle_cycles(10, '1, 0);

    for (int k = 0; k < 1500; k++) begin
      int lval;
      lval = ($urandom_range(0, 15) == 0) ? 255 :
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 20);
      if (k == 700) async_reset(1);
      cycle(N'($urandom) | N'($urandom), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 7), lval, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7));
    end

    idle_cycles(2, '1, 0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised, multi-channel successor to the single 5-bit down-counter timer.
- N independent down-counters of WIDTH bits, each with its own state machine.
- Each channel runs in one-shot or periodic (auto-reload) mode.
- Sits beside the control FSMs and provides trigger pulses and done flags; a CPU-side load/readback port programs and observes the channels.

Parameters:
- N_CHAN, 4, number of independent timer channels (1..16)
- WIDTH, 16, counter and load-value width in bits (2..32)
- CHAN_W, $clog2(N_CHAN) (min 1), width of channel-select fields (derived, not overridden)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all channel state immediately
- enable  input  N_CHAN  per-channel count enable; 0 freezes that channel
- load_valid  input  1  load strobe, one load per cycle
- load_chan  input  CHAN_W  channel targeted by load
- load_value  input  WIDTH  initial and reload count
- load_mode  input  1  0 = one-shot, 1 = periodic
- rd_chan  input  CHAN_W  readback channel select
- rd_count  output  WIDTH  current count of channel rd_chan (combinational mux)
- trigger  output  N_CHAN  registered one-cycle expiry pulse per channel
- done  output  N_CHAN  per-channel level: one-shot expired, holds until next load
- busy  output  N_CHAN  per-channel level: channel in COUNT state
- irq  output  1  OR of trigger

Behaviour:

Per-channel state:
- count[WIDTH], reload[WIDTH], mode, state in {IDLE, COUNT, DONE}.

Reset (asynchronous, active-high):
- count=0, reload=0, mode=0, state=IDLE.
- trigger=0, done=0, busy=0, irq=0.
- rd_count=0.
- Reset mid-count aborts with no trigger.

Load:
- Applies when load_valid=1 and load_chan==i.
- Sets count<=load_value, reload<=load_value, mode<=load_mode.
- Next state is COUNT if load_value!=0, else IDLE (a zero load stops and clears the channel).
- Load has priority over decrement and expiry in the same cycle: no trigger is generated that cycle.
- load_chan>=N_CHAN is ignored.
- Load is accepted regardless of enable.

COUNT state:
- enable[i]=1 and count>1: count decrements by 1.
- enable[i]=1 and count==1 (expiry): trigger[i]=1 on the next cycle for exactly one cycle.
  - One-shot: count<=0, state<=DONE.
  - Periodic: count<=reload, stay in COUNT.
- enable[i]=0: count and state hold; an expiry is deferred, never lost.

Latency and period:
- A load of V (V>0) with enable held high asserts trigger V cycles after the load edge.
- In periodic mode, triggers repeat every V cycles.
- Special case V=1 periodic: trigger stays high every cycle.

IDLE / DONE states:
- Count holds; enable has no effect.
- DONE exits only on a load; IDLE exits only on a non-zero load.

Output decode:
- done[i] = (state==DONE).
- busy[i] = (state==COUNT).

Arithmetic:
- Unsigned, no wrap: count never decrements below 0.
- Maximum load value is 2^WIDTH-1, giving 2^WIDTH-1 cycles to expiry.

Readback:
- rd_count reflects registered count with no extra latency.
- rd_chan>=N_CHAN returns 0.

Independence:
- Channels share no state; simultaneous expiries on multiple channels raise multiple trigger bits in the same cycle.

Decomposition:
- Package multi_timer_pkg holds:
  - state enum t_state {IDLE, COUNT, DONE}, 2 bits
  - constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
- One sub-module, timer_channel (parameter WIDTH):
  - one channel's registers, FSM and trigger flop
  - inputs: load strobe already qualified by channel match
- Top level contains only:
  - a generate loop of N_CHAN timer_channel instances
  - load-select decode
  - readback mux
  - irq OR

Test Plan:
1. Reset then load ch0 value 5 one-shot, enable=all 1 -> rd_count(ch0) reads 4,3,2,1,0; trigger[0]=1 for one cycle 5 cycles after load; done[0]=1 thereafter; busy[0]=0.
2. Load ch1 value 3 periodic, enable held -> trigger[1] pulses every 3 cycles for 4 periods; done[1] stays 0; count sequence 3,2,1,3,2,1.
3. Load ch2 value 4; drop enable[2] for 3 cycles at count 2 -> count holds at 2; trigger arrives exactly 3 cycles later than in scenario 1 timing.
4. Ch3 at count 1 with enable high; reload with value 7 in the same cycle -> no trigger; count=7 next cycle; load value 0 afterwards -> state IDLE, busy[3]=0, count 0.
5. Ch0 and ch1 loaded so they expire in the same cycle -> trigger=4'b0011 for one cycle; irq=1 for that cycle only.
6. Assert reset asynchronously (between clock edges) mid-count on all channels -> trigger, done and busy all 0 immediately; counts 0; no pulse after reset release.
